// File: rtl/memory_pkg.sv
// memory_pkg: shared encodings for the memory stage (FSM states, access sizes, write-back selects, cause codes).
package memory_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] WRITE_SEL_ALU = 2'd0;
  localparam logic [1:0] WRITE_SEL_LOAD = 2'd1;
  localparam logic [1:0] WRITE_SEL_CSR = 2'd2;
  localparam logic [1:0] WRITE_SEL_PC = 2'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    return (size == SIZE_HALF && offset[0]) || (size == SIZE_WORD && offset != 2'b00);
  endfunction
endpackage

// File: rtl/memory_load_align.sv
// load_align: picks the addressed byte/half/word out of a bus word and zero- or sign-extends it.
module load_align
  import memory_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);
  logic [31:0] shifted;
  assign shifted = rdata >> {offset, 3'b000};
  assign data = size == SIZE_BYTE ? {{24{sign && shifted[7]}}, shifted[7:0]} :
                size == SIZE_HALF ? {{16{sign && shifted[15]}}, shifted[15:0]} : rdata;
endmodule

// File: rtl/memory.sv
// memory: pipeline memory stage; drives a req/ready data bus for loads and stores and registers results for writeback.
module memory
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] csr_data_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_address_in,
  input  logic [11:0] csr_address_in,
  input  logic        csr_write_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [3:0]  ecause_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strobe,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_address_out,
  output logic [11:0] csr_address_out,
  output logic        csr_write_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out,
  output logic [31:0] load_data_out
);
  state_t state, next_state;
  logic access, bad_align, update, killed;
  logic [3:0] mask;
  logic [31:0] fmt_data, hold_data;
  assign access = valid_in && !exception_in && !invalidate && (load_in || store_in);
  assign bad_align = access && misaligned(size_in, alu_data_in[1:0]);
  assign mem_address = {alu_data_in[31:2], 2'b00};
  assign mask = size_in == SIZE_BYTE ? 4'b0001 : size_in == SIZE_HALF ? 4'b0011 : 4'b1111;
  assign mem_strobe = mask << alu_data_in[1:0];
  assign mem_wdata = size_in == SIZE_BYTE ? {4{store_data_in[7:0]}} :
                     size_in == SIZE_HALF ? {2{store_data_in[15:0]}} : store_data_in;
  assign mem_write = mem_req && store_in;
  assign busy = mem_req && !mem_ready;
  assign update = !stall && !busy;
  // rst_n gates the request so an asserted reset drops it at once, even mid-transaction
  always_comb begin
    mem_req = rst_n && (state == WAIT || (state == IDLE && access && !bad_align));
    next_state = state == DONE ? (stall ? DONE : IDLE) :
                 !mem_req ? IDLE : !mem_ready ? WAIT : stall ? DONE : IDLE;
  end
  load_align u_align (
    .rdata (mem_rdata),
    .offset(alu_data_in[1:0]),
    .size  (size_in),
    .sign  (signed_in),
    .data  (fmt_data)
  );
  // killed remembers an invalidate seen while the bus was still busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_data <= '0;
      killed <= 1'b0;
    end else begin
      state <= next_state;
      if (mem_req && mem_ready) hold_data <= fmt_data;
      if (update) killed <= 1'b0;
      else if (state == WAIT && invalidate) killed <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out <= '0;
      next_pc_out <= '0;
      alu_data_out <= '0;
      csr_data_out <= '0;
      write_select_out <= '0;
      rd_address_out <= '0;
      csr_address_out <= '0;
      csr_write_out <= 1'b0;
      mret_out <= 1'b0;
      wfi_out <= 1'b0;
      valid_out <= 1'b0;
      exception_out <= 1'b0;
      ecause_out <= '0;
      load_data_out <= '0;
    end else if (update) begin
      pc_out <= pc_in;
      next_pc_out <= next_pc_in;
      alu_data_out <= alu_data_in;
      csr_data_out <= csr_data_in;
      write_select_out <= write_select_in;
      rd_address_out <= rd_address_in;
      csr_address_out <= csr_address_in;
      csr_write_out <= csr_write_in;
      mret_out <= mret_in;
      wfi_out <= wfi_in;
      valid_out <= valid_in && !invalidate && !killed;
      exception_out <= exception_in || bad_align;
      ecause_out <= bad_align ? (store_in ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED) : ecause_in;
      load_data_out <= state == DONE ? hold_data : fmt_data;
    end
  end
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed vectors with a writeback scoreboard and a bus monitor for the memory stage.
module tb_memory;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] pc_in = '0, next_pc_in = '0, alu_data_in = '0, store_data_in = '0, csr_data_in = '0;
  logic [1:0] write_select_in = '0, size_in = '0;
  logic [4:0] rd_address_in = '0;
  logic [11:0] csr_address_in = '0;
  logic csr_write_in = 0, mret_in = 0, wfi_in = 0, load_in = 0, store_in = 0, signed_in = 0;
  logic valid_in = 0, exception_in = 0, stall = 0, invalidate = 0, mem_ready = 0;
  logic [3:0] ecause_in = '0;
  logic [31:0] mem_rdata = '0;
  logic busy, mem_req, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0] mem_strobe;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
  logic [1:0] write_select_out;
  logic [4:0] rd_address_out;
  logic [11:0] csr_address_out;
  logic csr_write_out, mret_out, wfi_out, valid_out, exception_out;
  logic [3:0] ecause_out;

  memory dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .store_data_in(store_data_in), .csr_data_in(csr_data_in), .write_select_in(write_select_in),
    .rd_address_in(rd_address_in), .csr_address_in(csr_address_in), .csr_write_in(csr_write_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .load_in(load_in), .store_in(store_in), .size_in(size_in),
    .signed_in(signed_in), .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
    .stall(stall), .invalidate(invalidate), .busy(busy), .mem_req(mem_req), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_strobe(mem_strobe), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
    .csr_data_out(csr_data_out), .write_select_out(write_select_out), .rd_address_out(rd_address_out),
    .csr_address_out(csr_address_out), .csr_write_out(csr_write_out), .mret_out(mret_out),
    .wfi_out(wfi_out), .valid_out(valid_out), .exception_out(exception_out), .ecause_out(ecause_out),
    .load_data_out(load_data_out)
  );

  typedef struct {
    bit vld, exc; logic [3:0] cin;
    bit ld, st; logic [1:0] sz; bit sgn;
    logic [31:0] addr, sd, rd;
    int dly, stl, inv;
    bit ereq, ewr; logic [3:0] estb; logic [31:0] ewd;
    bit chk_ld; logic [31:0] eld;
    bit evld, eexc; logic [3:0] ecause; int ebusy;
  } vec_t;
  typedef struct {
    bit evld, eexc; logic [3:0] ecause; bit chk_ld; logic [31:0] eld, pc, alu;
    logic [4:0] rd; logic [16:0] ctl;
  } wb_t;
  typedef struct { logic [31:0] addr, wd; logic [3:0] stb; bit wr; } bus_t;

  vec_t vecs[$];
  wb_t wb_q[$];
  bus_t bus_q[$];
  int checks = 0, fails = 0;
  bit track = 0, pend = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // writeback monitor: an update edge is one where stall and busy were both low just before it
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (wb_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL wb_unexpected: output update with no expectation queued");
        end else begin
          e = wb_q.pop_front();
          chk("valid_out", {31'b0, valid_out}, {31'b0, e.evld});
          if (e.evld) begin
            chk("exception_out", {31'b0, exception_out}, {31'b0, e.eexc});
            if (e.eexc) chk("ecause_out", {28'b0, ecause_out}, {28'b0, e.ecause});
            if (e.chk_ld) chk("load_data_out", load_data_out, e.eld);
            chk("pc_out", pc_out, e.pc);
            chk("next_pc_out", next_pc_out, e.pc + 32'd4);
            chk("alu_data_out", alu_data_out, e.alu);
            chk("csr_data_out", csr_data_out, ~e.pc);
            chk("rd_address_out", {27'b0, rd_address_out}, {27'b0, e.rd});
            chk("ctl_out", {15'b0, csr_write_out, mret_out, wfi_out, write_select_out, csr_address_out},
                {15'b0, e.ctl});
          end
        end
      end
      pend = track && rst_n && !stall && !busy;
    end
  end

  // bus monitor: any request must be expected; each handshake is compared against its entry
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        checks++;
        if (bus_q.size() == 0) begin
          fails++;
          $display("FAIL bus_unexpected_req: mem_req=1 addr=%h write=%b, expected no request", mem_address, mem_write);
        end else if (mem_ready) begin
          b = bus_q.pop_front();
          chk("mem_address", mem_address, b.addr);
          chk("mem_write", {31'b0, mem_write}, {31'b0, b.wr});
          if (b.wr) begin
            chk("mem_strobe", {28'b0, mem_strobe}, {28'b0, b.stb});
            chk("mem_wdata", mem_wdata, b.wd);
          end
        end
      end
    end
  end

  task automatic run(input vec_t v, input int idx);
    wb_t w;
    logic [31:0] pc;
    logic [16:0] ctl;
    int cyc, bc;
    bit fin;
    pc = 32'h1000 + idx * 4;
    ctl = {idx[0], idx[1], idx[2], idx[1:0], 12'h300 + idx[11:0]};
    w = '{v.evld, v.eexc, v.ecause, v.chk_ld, v.eld, pc, v.addr, idx[4:0], ctl};
    wb_q.push_back(w);
    if (v.ereq) bus_q.push_back('{{v.addr[31:2], 2'b00}, v.ewd, v.estb, v.ewr});
    @(posedge clk); #1;
    pc_in = pc; next_pc_in = pc + 32'd4; csr_data_in = ~pc; alu_data_in = v.addr; store_data_in = v.sd;
    rd_address_in = idx[4:0]; {csr_write_in, mret_in, wfi_in, write_select_in, csr_address_in} = ctl;
    valid_in = v.vld; exception_in = v.exc; ecause_in = v.cin;
    load_in = v.ld; store_in = v.st; size_in = v.sz; signed_in = v.sgn;
    mem_ready = v.dly == 0; mem_rdata = mem_ready ? v.rd : 32'h0;
    stall = v.stl > 0; invalidate = v.inv == 1;
    track = 1; cyc = 0; bc = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      fin = !stall && !busy;
      if (busy) bc++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 60) begin
        $display("FAIL timeout: vector %0d never completed after %0d cycles", idx, cyc);
        $display("%0d/%0d checks passed", checks - fails, checks + 1);
        $fatal(1);
      end
      mem_ready = cyc == v.dly; mem_rdata = mem_ready ? v.rd : 32'h0;
      stall = cyc < v.stl; invalidate = v.inv == 1 || (v.inv == 2 && cyc == 1);
    end
    track = 0; valid_in = 0; load_in = 0; store_in = 0; exception_in = 0;
    invalidate = 0; stall = 0; mem_ready = 0;
    chk($sformatf("busy_cycles[%0d]", idx), bc, v.ebusy);
  endtask

  initial begin
    vecs.push_back('{1,0,0, 1,0,2,0, 32'h104,0,32'hDEADBEEF, 3,0,0, 1,0,0,0, 1,32'hDEADBEEF, 1,0,0,3});
    vecs.push_back('{1,0,0, 1,0,0,1, 32'h103,0,32'h80112233, 1,0,0, 1,0,0,0, 1,32'hFFFFFF80, 1,0,0,1});
    vecs.push_back('{1,0,0, 1,0,0,0, 32'h103,0,32'h80112233, 1,0,0, 1,0,0,0, 1,32'h00000080, 1,0,0,1});
    vecs.push_back('{1,0,0, 0,1,1,0, 32'h102,32'h1234,0, 2,0,0, 1,1,4'b1100,32'h12341234, 0,0, 1,0,0,2});
    vecs.push_back('{1,0,0, 1,0,2,0, 32'h101,0,0, 0,0,0, 0,0,0,0, 0,0, 1,1,4,0});
    vecs.push_back('{1,0,0, 0,1,2,0, 32'h101,32'h77,0, 0,0,0, 0,0,0,0, 0,0, 1,1,6,0});
    vecs.push_back('{1,0,0, 0,1,2,0, 32'h108,32'hCAFEF00D,0, 0,4,0, 1,1,4'hF,32'hCAFEF00D, 0,0, 1,0,0,0});
    vecs.push_back('{1,0,0, 1,0,2,0, 32'h10C,0,32'h11111111, 2,0,2, 1,0,0,0, 0,0, 0,0,0,2});
    vecs.push_back('{1,0,0, 1,0,1,0, 32'h106,0,32'hABCD1234, 1,0,0, 1,0,0,0, 1,32'h0000ABCD, 1,0,0,1});
    vecs.push_back('{1,0,0, 1,0,1,1, 32'h106,0,32'hABCD1234, 1,0,0, 1,0,0,0, 1,32'hFFFFABCD, 1,0,0,1});
    vecs.push_back('{1,0,0, 0,1,0,0, 32'h101,32'hA5,0, 1,0,0, 1,1,4'b0010,32'hA5A5A5A5, 0,0, 1,0,0,1});
    vecs.push_back('{1,0,0, 0,0,2,0, 32'h55,0,0, 0,0,0, 0,0,0,0, 0,0, 1,0,0,0});
    vecs.push_back('{0,0,0, 1,0,2,0, 32'h104,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0,0,0});
    vecs.push_back('{1,1,2, 1,0,2,0, 32'h104,0,0, 0,0,0, 0,0,0,0, 0,0, 1,1,2,0});
    vecs.push_back('{1,0,0, 1,0,1,0, 32'h103,0,0, 0,0,0, 0,0,0,0, 0,0, 1,1,4,0});
    vecs.push_back('{1,0,0, 1,0,2,0, 32'h104,0,0, 0,0,1, 0,0,0,0, 0,0, 0,0,0,0});
    vecs.push_back('{1,0,0, 1,0,2,0, 32'h110,0,32'h0BADF00D, 2,3,0, 1,0,0,0, 1,32'h0BADF00D, 1,0,0,2});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_out", {31'b0, valid_out}, 32'd0);
    chk("reset_exception_out", {31'b0, exception_out}, 32'd0);
    chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset_load_data_out", load_data_out, 32'd0);
    @(posedge clk); #1 rst_n = 1;
    foreach (vecs[i]) run(vecs[i], i);
    @(posedge clk); #1;
    chk("bus_queue_drained", bus_q.size(), 32'd0);
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    // reset while a load is stuck waiting for the bus
    bus_q.push_back('{32'h120, 32'h0, 4'h0, 1'b0});
    valid_in = 1; load_in = 1; size_in = 2'd2; alu_data_in = 32'h120; mem_ready = 0;
    @(negedge clk);
    chk("req_before_reset", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #1;
    chk("busy_in_wait", {31'b0, busy}, 32'd1);
    rst_n = 0;
    #1;
    chk("reset_mid_wait_mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset_mid_wait_valid_out", {31'b0, valid_out}, 32'd0);
    chk("reset_mid_wait_busy", {31'b0, busy}, 32'd0);
    valid_in = 0; load_in = 0;
    bus_q.delete();
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("after_reset_mem_req", {31'b0, mem_req}, 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
